// File: rtl/clock_pkg.sv
// Shared definitions for the timekeeping blocks: BCD digit width, digit
// limits and the countdown timer state encoding.
package clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with a parallel load.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset (digit clears to 0)
//   dec_en     decrement this digit on the next edge
//   load       take d on the next edge (wins over dec_en)
//   d          value to load
//   q          current digit value
//   borrow_out high when this digit wraps on a decrement; it feeds the
//              dec_en of the next more significant digit
module bcd_down_digit
  import clock_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] WRAP_VAL = DIGIT_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (dec_en) begin
      q_d = (q_q == '0) ? WRAP_VAL : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = (q_q == '0) && dec_en;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer built from four chained BCD down-digits. It is
// loaded with a preset, counts down once per tick while running, pulses
// done on reaching 00:00 and then holds alarm high for ALARM_LEN ticks or
// until acknowledged with start/stop.
//
// Optional feature (macro BCD_TIMER_AUTO_RELOAD_EN): the last valid preset
// is kept in a shadow register; when the count would reach 00:00 in RUN the
// digits reload the shadow value, done pulses and counting continues. A
// zero shadow falls back to normal expiry.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   tick                       one-cycle 1 Hz enable
//   load, ld_min_t..ld_sec_u   preset load strobe and BCD preset digits
//   start, stop                begin/resume and pause (also ack the alarm)
//   min_t, min_u, sec_t, sec_u current digits
//   running                    high while in RUN
//   done                       one-cycle pulse on reaching 00:00
//   alarm                      high while in EXPIRED
//   load_err                   one-cycle pulse on a rejected load
//
// Cycle priority: reset > load > stop > start > tick. A load, valid or not,
// consumes the cycle.
module bcd_countdown_timer
  import clock_pkg::*;
#(
  parameter int MIN_TENS_MAX = 9,
  parameter int ALARM_LEN    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [DIGIT_W-1:0] MIN_T_LIMIT = DIGIT_W'(MIN_TENS_MAX);
  localparam logic [7:0]         ALARM_LAST  = 8'(ALARM_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;
  logic       load_err_q, load_err_d;

  logic [DIGIT_W-1:0] min_t_w, min_u_w, sec_t_w, sec_u_w;
  logic [15:0]        digits_w;
  logic [15:0]        preset_w;
  logic [15:0]        load_val;
  logic               ld_valid;
  logic               is_zero;
  logic               at_one;
  logic               reload_now;
  logic               dig_load;
  logic               dec_en;
  logic               b_sec_u, b_sec_t, b_min_u;
  logic               min_t_borrow_unused;

  assign digits_w = {min_t_w, min_u_w, sec_t_w, sec_u_w};
  assign preset_w = {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u};
  assign ld_valid = (ld_min_t <= MIN_T_LIMIT) && (ld_min_u <= DIGIT_MAX) &&
                    (ld_sec_t <= SEC_TENS_MAX) && (ld_sec_u <= DIGIT_MAX);
  assign is_zero  = (digits_w == 16'h0000);
  // The decrement that lands on 00:00 is the one taken from 00:01.
  assign at_one   = (digits_w == 16'h0001);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [15:0] shadow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (load && ld_valid) begin
      shadow_q <= preset_w;
    end
  end

  assign reload_now = at_one && (shadow_q != 16'h0000);
  assign load_val   = reload_now ? shadow_q : preset_w;
`else
  assign reload_now = 1'b0;
  assign load_val   = preset_w;
`endif

  always_comb begin
    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;
    load_err_d  = 1'b0;
    dig_load    = 1'b0;
    dec_en      = 1'b0;
    if (load) begin
      if (ld_valid) begin
        dig_load    = 1'b1;
        state_d     = IDLE;
        alarm_cnt_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q != IDLE) begin
        state_d     = IDLE;
        alarm_cnt_d = '0;
      end
    end else if (start) begin
      case (state_q)
        IDLE: begin
          if (!is_zero) state_d = RUN;
        end
        EXPIRED: begin
          state_d     = IDLE;
          alarm_cnt_d = '0;
        end
        default: ;
      endcase
    end else if (tick) begin
      case (state_q)
        RUN: begin
          done_d = at_one;
          if (reload_now) begin
            dig_load = 1'b1;
          end else begin
            dec_en = 1'b1;
            if (at_one) begin
              state_d     = EXPIRED;
              alarm_cnt_d = '0;
            end
          end
        end
        EXPIRED: begin
          if (alarm_cnt_q == ALARM_LAST) begin
            state_d     = IDLE;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    // Status flags are registered copies of the next state so they line up
    // with the state register.
    running_d = (state_d == RUN);
    alarm_d   = (state_d == EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      done_q      <= done_d;
      alarm_q     <= alarm_d;
      load_err_q  <= load_err_d;
    end
  end

  bcd_down_digit #(.WRAP_VAL(DIGIT_MAX)) u_sec_u (
    .clk(clk), .reset(reset), .dec_en(dec_en), .load(dig_load),
    .d(load_val[3:0]), .q(sec_u_w), .borrow_out(b_sec_u)
  );

  bcd_down_digit #(.WRAP_VAL(SEC_TENS_MAX)) u_sec_t (
    .clk(clk), .reset(reset), .dec_en(b_sec_u), .load(dig_load),
    .d(load_val[7:4]), .q(sec_t_w), .borrow_out(b_sec_t)
  );

  bcd_down_digit #(.WRAP_VAL(DIGIT_MAX)) u_min_u (
    .clk(clk), .reset(reset), .dec_en(b_sec_t), .load(dig_load),
    .d(load_val[11:8]), .q(min_u_w), .borrow_out(b_min_u)
  );

  // RUN is never entered at 00:00, so the top digit never borrows.
  bcd_down_digit #(.WRAP_VAL(DIGIT_MAX)) u_min_t (
    .clk(clk), .reset(reset), .dec_en(b_min_u), .load(dig_load),
    .d(load_val[15:12]), .q(min_t_w), .borrow_out(min_t_borrow_unused)
  );

  assign min_t    = min_t_w;
  assign min_u    = min_u_w;
  assign sec_t    = sec_t_w;
  assign sec_u    = sec_u_w;
  assign running  = running_q;
  assign done     = done_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer. The reference model keeps the remaining
// time as a plain number of seconds and the mode as a small integer; the
// expected output word for every driven cycle is queued and a monitor
// compares it against the DUT after the following clock edge.
module tb_bcd_countdown_timer;

  localparam int MTM = 5;
  localparam int AL  = 3;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       load;
  logic [3:0] ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;
  logic       start;
  logic       stop;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       running, done, alarm, load_err;

  bcd_countdown_timer #(
    .MIN_TENS_MAX(MTM),
    .ALARM_LEN   (AL)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .ld_min_t(ld_min_t), .ld_min_u(ld_min_u),
    .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
    .start(start), .stop(stop),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .running(running), .done(done), .alarm(alarm), .load_err(load_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [19:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc_n = 0;

  // reference model state
  int m_t      = 0;
  int m_mode   = M_IDLE;
  int m_acnt   = 0;
  int m_shadow = 0;

  function automatic logic [19:0] pack_exp(input int t, input logic r, input logic dn,
                                           input logic al, input logic le);
    int mins;
    int secs;
    mins = t / 60;
    secs = t % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), r, dn, al, le};
  endfunction

  // One clock cycle of stimulus plus the model's view of its outcome.
  task automatic cyc(input logic r, input logic ld, input logic [3:0] mt, input logic [3:0] mu,
                     input logic [3:0] st, input logic [3:0] su,
                     input logic go, input logic halt, input logic tk);
    logic dn;
    logic le;
    int   preset;
    @(negedge clk);
    reset    = r;
    load     = ld;
    ld_min_t = mt;
    ld_min_u = mu;
    ld_sec_t = st;
    ld_sec_u = su;
    start    = go;
    stop     = halt;
    tick     = tk;
    dn = 1'b0;
    le = 1'b0;
    preset = (int'(mt) * 10 + int'(mu)) * 60 + int'(st) * 10 + int'(su);
    if (r) begin
      m_t = 0; m_mode = M_IDLE; m_acnt = 0; m_shadow = 0;
    end else if (ld) begin
      if (int'(mt) <= MTM && mu <= 4'd9 && st <= 4'd5 && su <= 4'd9) begin
        m_t = preset; m_mode = M_IDLE; m_acnt = 0;
        if (AUTO) m_shadow = preset;
      end else begin
        le = 1'b1;
      end
    end else if (halt) begin
      m_mode = M_IDLE; m_acnt = 0;
    end else if (go) begin
      if (m_mode == M_IDLE && m_t != 0) m_mode = M_RUN;
      else if (m_mode == M_EXP) begin m_mode = M_IDLE; m_acnt = 0; end
    end else if (tk) begin
      if (m_mode == M_RUN) begin
        m_t = m_t - 1;
        if (m_t == 0) begin
          dn = 1'b1;
          if (AUTO && m_shadow != 0) m_t = m_shadow;
          else begin m_mode = M_EXP; m_acnt = 0; end
        end
      end else if (m_mode == M_EXP) begin
        m_acnt = m_acnt + 1;
        if (m_acnt == AL) begin m_mode = M_IDLE; m_acnt = 0; end
      end
    end
    exp_q.push_back(pack_exp(m_t, m_mode == M_RUN, dn, m_mode == M_EXP, le));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input logic [3:0] mt, input logic [3:0] mu,
                         input logic [3:0] st, input logic [3:0] su);
    cyc(0, 1, mt, mu, st, su, 0, 0, 0);
  endtask

  task automatic do_start();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // monitor: one expected word per driven cycle
  logic [19:0] mon_exp;
  logic [19:0] mon_got;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {min_t, min_u, sec_t, sec_u, running, done, alarm, load_err};
      cyc_n++;
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL outputs cyc=%0d got digits=%04h run/done/alarm/lerr=%04b required digits=%04h run/done/alarm/lerr=%04b",
                 cyc_n, mon_got[19:4], mon_got[3:0], mon_exp[19:4], mon_exp[3:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    ld_min_t = '0; ld_min_u = '0; ld_sec_t = '0; ld_sec_u = '0;

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // start at 00:00 is ignored
    do_start();

    // 01:05 countdown through the minute borrow to expiry and alarm timeout
    do_load(0, 1, 0, 5);
    do_start();
    for (int i = 0; i < 65; i++) begin
      do_tick();
      idle($urandom_range(0, 2));
    end
    for (int i = 0; i < AL + 1; i++) begin
      do_tick();
      idle(1);
    end

    // full borrow chain 10:00 -> 09:59 (10 minutes rejected by MTM=5, so 05:00 -> 04:59)
    do_load(1, 0, 0, 0);
    do_load(5, 0, 0, 0);
    do_start();
    do_tick();
    idle(1);

    // rejected loads leave digits and state alone
    do_load(0, 0, 6, 0);
    do_load(9, 0, 0, 0);
    do_load(0, 10, 0, 0);
    do_load(0, 0, 0, 12);
    do_tick();

    // stop wins over tick; start with tick does not count
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    do_tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    do_tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_tick();

    // expire, then acknowledge the alarm with start, then with stop
    do_load(0, 0, 0, 2);
    do_start();
    do_tick();
    do_tick();
    do_tick();
    do_start();
    idle(2);
    do_load(0, 0, 0, 1);
    do_start();
    do_tick();
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // load while expired clears the alarm
    do_load(0, 0, 0, 1);
    do_start();
    do_tick();
    do_load(0, 0, 3, 0);

    // 00:02 run-out (auto reload when enabled), then reset mid-run
    do_load(0, 0, 0, 2);
    do_start();
    do_tick();
    do_tick();
    do_tick();
    do_tick();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic       r, ld, go, halt, tk;
      logic [3:0] mt, mu, st, su;
      r    = ($urandom_range(0, 299) == 0);
      ld   = ($urandom_range(0, 29) == 0);
      mt   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      mu   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      st   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 1));
      su   = 4'($urandom_range(0, 11));
      go   = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 39) == 0);
      tk   = ($urandom_range(0, 2) == 0);
      cyc(r, ld, mt, mu, st, su, go, halt, tk);
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending required=0 pending", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- MM:SS countdown timer built from four BCD digits. Each digit counts down and borrows from the next digit up.
- It is the down-counting counterpart to the clock's up-counting BCD digit counters. It is loaded with a preset, decrements once per 1 Hz `tick`, then signals expiry and raises a timed alarm.
- Sits beside the timekeeping chain and shares the `tick` enable and the display digit format.

Parameters:
- MIN_TENS_MAX, 9, largest legal minutes-tens digit; loads above it are rejected.
- ALARM_LEN, 10, number of `tick`s `alarm` stays high after expiry (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; clock is clk
- tick  in  1  one-cycle 1 Hz enable strobe
- load  in  1  load preset digits
- ld_min_t  in  4  preset minutes tens (BCD)
- ld_min_u  in  4  preset minutes units (BCD)
- ld_sec_t  in  4  preset seconds tens (BCD, 0..5)
- ld_sec_u  in  4  preset seconds units (BCD)
- start  in  1  begin or resume counting
- stop  in  1  pause counting
- min_t, min_u, sec_t, sec_u  out  4 each  current digits
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on reaching 00:00
- alarm  out  1  high while in EXPIRED
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset values: all digits 0, state IDLE, running=0, done=0, alarm=0, load_err=0, alarm counter 0.
- States:
  - IDLE: loaded or paused, not counting.
  - RUN: decrementing.
  - EXPIRED: alarm active.
- Per-cycle priority: reset > load > stop > start > tick.
- Load, in any state:
  - Valid when min_t<=MIN_TENS_MAX, min_u<=9, sec_t<=5 and sec_u<=9.
  - Valid: digits take the preset next edge, state goes to IDLE, alarm clears.
  - Invalid: load_err=1 for one cycle; digits and state unchanged.
- IDLE:
  - start with digits != 00:00 goes to RUN next edge.
  - start at 00:00 is ignored.
  - A tick in the same cycle as start is not counted; the first decrement is on the next tick.
- RUN:
  - stop goes to IDLE and wins over a coincident tick (no decrement).
  - start has no effect.
  - tick decrements with borrow chain:
    - sec_u 0→9 borrows from sec_t.
    - sec_t 0→5 borrows from min_u.
    - min_u 0→9 borrows from min_t.
    - min_t decrements and never underflows, since RUN is never at 00:00.
- Expiry: the tick whose result is 00:00 sets done=1 on the following cycle (registered, exactly one cycle) and moves the state to EXPIRED.
- EXPIRED:
  - alarm=1.
  - Each tick increments the alarm counter; after ALARM_LEN ticks, go to IDLE with alarm=0.
  - start or stop acknowledges immediately: go to IDLE, alarm clears next edge.
  - Digits hold at 00:00.
- running is derived registered from the state (state==RUN); all outputs are registered.
- Reset mid-run discards the count; no done pulse.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- When defined:
  - A shadow register stores the last valid preset; reset sets it to 00:00.
  - On the tick that would produce 00:00 in RUN, digits instead load the shadow value, done pulses, and the state stays in RUN.
  - EXPIRED is never entered in this case.
  - If the shadow is 00:00, behaviour is as without the macro.
- When undefined: no shadow register; expiry behaves as described above.

Decomposition:
- Shared package `clock_pkg`:
  - BCD digit width constant (4).
  - Constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
  - State enum {IDLE, RUN, EXPIRED}.
- Sub-module `bcd_down_digit`, instantiated four times:
  - Parameter WRAP_VAL.
  - Inputs: dec_en, load, d.
  - Outputs: q, borrow_out. borrow_out is combinational and equals (q==0) && dec_en.
  - Chain each digit's borrow_out to the next digit's dec_en.

Test Plan:
- Load 01:05, start, apply 65 ticks → digits step 01:05, 01:04 … 01:00, 00:59 … 00:00; done pulses exactly once, one cycle after the final tick; alarm=1.
- Load 10:00, start, 1 tick → 09:59 (full borrow chain).
- Load ld_sec_t=6 → load_err pulse; digits unchanged. Load min_t=9 with MIN_TENS_MAX=5 → rejected.
- In RUN, assert stop together with tick → no decrement, running=0. Then start together with tick → no decrement; the next tick decrements.
- Expire with ALARM_LEN=3 → alarm high for 3 ticks, then IDLE. Repeat and assert start during alarm → alarm low next cycle.
- With the macro defined, load 00:02, start, 2 ticks → done pulse; digits 00:02; running stays 1. Reset mid-run → all outputs 0 next edge.
